esc_array: RTL



---
 rtl/esc_pkg.sv | 20 ++
 rtl/esc_chan.sv | 73 +++++++
 rtl/esc_array.sv | 106 ++++++++++
 3 files changed

// File: rtl/esc_pkg.sv
// Shared definitions for the ESC pulse generator array.
// Holds the arming FSM state type and the default build parameters.
// Latency / flow control: not applicable (types and constants only).
package esc_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2
  } esc_state_e;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_SPEED_W    = 11;
  localparam int DEF_PERIOD_CYC = 125000;
  localparam int DEF_MIN_PULSE  = 50000;
  localparam int DEF_SCALE      = 25;
  localparam int DEF_SLEW_STEP  = 64;
  localparam int DEF_ARM_FRAMES = 50;

endpackage

// File: rtl/esc_chan.sv
// One ESC channel: target latch, per-frame slewed applied speed, pulse compare.
// Latency: pwm is registered, one cycle behind the shared frame counter.
// Flow control: none; wrt is accepted on any cycle, no backpressure.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   wrt, spd    load spd into target
//   frm_end     last cycle of the frame; applied steps toward target here
//   hold_zero   force applied to zero (not armed, or motors_off)
//   pulse_en    allow pwm high this cycle
//   cnt         shared frame counter
//   pwm         registered pulse output
module esc_chan
  import esc_pkg::*;
#(
  parameter int SPEED_W   = DEF_SPEED_W,
  parameter int CNT_W     = 17,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int SCALE     = DEF_SCALE,
  parameter int SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt,
  input  logic [SPEED_W-1:0] spd,
  input  logic               frm_end,
  input  logic               hold_zero,
  input  logic               pulse_en,
  input  logic [CNT_W-1:0]   cnt,
  output logic               pwm
);

  logic [SPEED_W-1:0] target;
  logic [SPEED_W-1:0] applied;
  logic [SPEED_W-1:0] applied_nxt;
  int                 tgt_i;
  int                 app_i;
  int                 nxt_i;
  int                 pulse_w;

  // Step toward target by at most SLEW_STEP; done in 32-bit integers so the
  // difference and the step never wrap at SPEED_W.
  always_comb begin
    tgt_i = int'(target);
    app_i = int'(applied);
    nxt_i = tgt_i;
    if (SLEW_STEP != 0) begin
      if (tgt_i > app_i) begin
        if (tgt_i - app_i > SLEW_STEP) nxt_i = app_i + SLEW_STEP;
      end else begin
        if (app_i - tgt_i > SLEW_STEP) nxt_i = app_i - SLEW_STEP;
      end
    end
    applied_nxt = SPEED_W'(nxt_i);
  end

  // Full-precision pulse width; the top level guarantees it stays below the frame.
  assign pulse_w = MIN_PULSE + int'(applied) * SCALE;

  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= '0;
      applied <= '0;
      pwm     <= 1'b0;
    end else begin
      if (wrt) target <= spd;
      // hold_zero wins over slew so motors_off drops the speed at once.
      if (hold_zero)    applied <= '0;
      else if (frm_end) applied <= applied_nxt;
      pwm <= pulse_en && (int'(cnt) < pulse_w);
    end
  end

endmodule

// File: rtl/esc_array.sv
// Multi-channel ESC PWM generator with arming sequence and speed slew limiting.
// Latency: pwm registered one cycle after cnt; speed changes land at frame ends.
// Flow control: none; wrt and motors_off are sampled every cycle.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   wrt          latch all spd channels into the target registers
//   motors_off   force zero speed and disarm
//   spd          packed speeds, channel i at [i*SPEED_W +: SPEED_W]
//   pwm          ESC pulse per channel
//   armed        high in ARMED
//   frm_end      one-cycle pulse on the last cycle of each frame
module esc_array
  import esc_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int SPEED_W    = DEF_SPEED_W,
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int MIN_PULSE  = DEF_MIN_PULSE,
  parameter int SCALE      = DEF_SCALE,
  parameter int SLEW_STEP  = DEF_SLEW_STEP,
  parameter int ARM_FRAMES = DEF_ARM_FRAMES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrt,
  input  logic                    motors_off,
  input  logic [N_CH*SPEED_W-1:0] spd,
  output logic [N_CH-1:0]         pwm,
  output logic                    armed,
  output logic                    frm_end
);

  localparam int               CNT_W    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int               ARM_W    = (ARM_FRAMES > 0) ? $clog2(ARM_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

  // The widest pulse must end before the frame does, otherwise pwm would
  // never fall and the counter compare would be meaningless.
  if (MIN_PULSE + ((1 << SPEED_W) - 1) * SCALE >= PERIOD_CYC) begin : g_bad_params
    $error("esc_array: widest pulse does not fit inside the PWM frame");
  end

  logic [CNT_W-1:0] cnt;
  logic [ARM_W-1:0] arm_cnt;
  esc_state_e       state;
  logic             hold_zero;
  logic             pulse_en;

  assign frm_end   = (cnt == CNT_LAST);
  assign armed     = (state == ST_ARMED);
  // motors_off is folded in directly so applied and pwm react in the same
  // cycle the state register is being cleared.
  assign hold_zero = (state != ST_ARMED) || motors_off;
  assign pulse_en  = (state != ST_DISARMED) && !motors_off;

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (frm_end) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_DISARMED;
      arm_cnt <= '0;
    end else if (motors_off) begin
      state   <= ST_DISARMED;
      arm_cnt <= '0;
    end else if (frm_end) begin
      case (state)
        ST_DISARMED: begin
          state   <= ST_ARMING;
          arm_cnt <= '0;
        end
        ST_ARMING: begin
          // Saturating count of completed arming frames.
          if (int'(arm_cnt) < ARM_FRAMES) arm_cnt <= arm_cnt + 1'b1;
          if (int'(arm_cnt) + 1 >= ARM_FRAMES) state <= ST_ARMED;
        end
        ST_ARMED: ;
        default: state <= ST_DISARMED;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    esc_chan #(
      .SPEED_W  (SPEED_W),
      .CNT_W    (CNT_W),
      .MIN_PULSE(MIN_PULSE),
      .SCALE    (SCALE),
      .SLEW_STEP(SLEW_STEP)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wrt      (wrt),
      .spd      (spd[i*SPEED_W +: SPEED_W]),
      .frm_end  (frm_end),
      .hold_zero(hold_zero),
      .pulse_en (pulse_en),
      .cnt      (cnt),
      .pwm      (pwm[i])
    );
  end

endmodule
